// File: rtl/burst_slave_port_if.sv
// Bus bundle for burst_slave_port: serial master side plus parallel target side.
`timescale 1ns/1ps
interface burst_slave_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              ss;
  logic              m_valid;
  logic              s_ready;
  logic              in_write;
  logic              in_addr;
  logic              ser_wdata;
  logic              burst_en;
  logic              ser_rdata;
  logic              ser_rvalid;
  logic              m_ready;
  logic              busy;
  logic              t_req;
  logic              t_write;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic              t_ack;
  logic [DATA_W-1:0] t_rdata;

  modport slave (
    input  ss, m_valid, in_write, in_addr, ser_wdata, burst_en, m_ready, t_ack, t_rdata,
    output s_ready, ser_rdata, ser_rvalid, busy, t_req, t_write, t_addr, t_wdata
  );

  modport master (
    output ss, m_valid, in_write, in_addr, ser_wdata, burst_en, m_ready,
    input  s_ready, ser_rdata, ser_rvalid, busy
  );

  modport target (
    input  t_req, t_write, t_addr, t_wdata,
    output t_ack, t_rdata
  );
endinterface

// File: rtl/burst_slave_port.sv
// Serial-to-parallel slave port: LSB-first address/data in, req/ack to target, read data out.
// Define BURST_SLAVE_PORT_BURST_EN to build burst continuation with address auto-increment.
`timescale 1ns/1ps
module burst_slave_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              in_clk,
  input  logic              reset_n,
  output logic              out_clk,
  burst_slave_port_if.slave bus
);
  // state    | meaning
  // ST_ADDR  | shifting in address bits; first bit latches direction
  // ST_WDATA | shifting in write data bits
  // ST_WREQ  | write request held to target until t_ack
  // ST_RREQ  | read request held to target until t_ack
  // ST_RDATA | shifting read data out to master
  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_WDATA,
    ST_WREQ,
    ST_RREQ,
    ST_RDATA
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              write_q, write_d;
  logic              hs_in;
  logic              hs_out;
  logic              burst_go;
  logic [ADDR_W-1:0] addr_inc;

  assign out_clk        = in_clk;
  assign bus.s_ready    = (state_q == ST_ADDR) || (state_q == ST_WDATA);
  assign bus.ser_rvalid = (state_q == ST_RDATA);
  assign bus.ser_rdata  = (state_q == ST_RDATA) && shift_q[0];
  assign bus.t_req      = (state_q == ST_WREQ) || (state_q == ST_RREQ);
  assign bus.busy       = !((state_q == ST_ADDR) && (cnt_q == '0));
  assign bus.t_write    = write_q;
  assign bus.t_addr     = addr_q;
  assign bus.t_wdata    = wdata_q;

  assign hs_in  = bus.ss && bus.m_valid && bus.s_ready;
  assign hs_out = bus.ss && bus.ser_rvalid && bus.m_ready;

`ifdef BURST_SLAVE_PORT_BURST_EN
  assign burst_go = bus.burst_en;
  assign addr_inc = addr_q + ADDR_W'(1);
`else
  // Without burst support every beat ends in ST_ADDR and burst_en is a don't-care.
  logic unused_burst_en;
  assign unused_burst_en = bus.burst_en;
  assign burst_go        = 1'b0;
  assign addr_inc        = addr_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    write_d = write_q;
    unique case (state_q)
      ST_ADDR: begin
        if (hs_in) begin
          addr_d = {bus.in_addr, addr_q[ADDR_W-1:1]};
          if (cnt_q == '0) write_d = bus.in_write;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = write_q ? ST_WDATA : ST_RREQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WDATA: begin
        if (hs_in) begin
          wdata_d = {bus.ser_wdata, wdata_q[DATA_W-1:1]};
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = ST_WREQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WREQ: begin
        if (bus.t_ack) begin
          cnt_d = '0;
          if (burst_go) begin
            addr_d  = addr_inc;
            state_d = ST_WDATA;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_RREQ: begin
        if (bus.t_ack) begin
          cnt_d   = '0;
          shift_d = bus.t_rdata;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (hs_out) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (burst_go) begin
              addr_d  = addr_inc;
              state_d = ST_RREQ;
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_ADDR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ADDR;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      shift_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      write_q <= write_d;
    end
  end
endmodule

// File: tb/tb_burst_slave_port.sv
// Scoreboard bench for burst_slave_port: transaction-level model, randomized serial stalls.
`timescale 1ns/1ps
module tb_burst_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic out_clk;
  always #5 clk = ~clk;

  burst_slave_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  burst_slave_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .in_clk (clk),
    .reset_n(rst_n),
    .out_clk(out_clk),
    .bus    (bus)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t          exp_req[$];
  logic          exp_bits[$];
  logic [DW-1:0] rd_q[$];
  int  total = 0;
  int  bad = 0;
  int  ack_delay = 0;
  bit  rand_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Target: acks each request after ack_delay cycles, returns queued read data, toggles stray acks while idle.
  initial begin
    int wcnt;
    bit acked;
    wcnt = 0;
    acked = 0;
    bus.t_ack = 1'b0;
    bus.t_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !bus.t_req) begin
        wcnt = 0;
        acked = 0;
        bus.t_ack = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
        bus.t_rdata = DW'($urandom);
      end else if (acked) begin
        bus.t_ack = 1'b1;
      end else if (wcnt >= ack_delay) begin
        bus.t_ack = 1'b1;
        acked = 1;
        if (!bus.t_write) bus.t_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : '0;
      end else begin
        bus.t_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Request monitor.
  initial begin
    logic prev;
    req_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.t_req && !prev) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got addr 0x%0h write %0b, expected no request", bus.t_addr, bus.t_write);
        end else begin
          e = exp_req.pop_front();
          check("req_write", 32'(bus.t_write), 32'(e.wr));
          check("req_addr", 32'(bus.t_addr), 32'(e.addr));
          if (e.wr) check("req_wdata", 32'(bus.t_wdata), 32'(e.data));
        end
      end
      prev = (rst_n === 1'b1) && bus.t_req;
    end
  end

  // Serial read-data monitor.
  initial begin
    logic b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.ser_rvalid) check("ready_rvalid_excl", 32'(bus.s_ready), 32'd0);
        if (bus.ss && bus.ser_rvalid && bus.m_ready) begin
          if (exp_bits.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rbit: got %0b, expected no read bit", bus.ser_rdata);
          end else begin
            b = exp_bits.pop_front();
            check("rbit", 32'(bus.ser_rdata), 32'(b));
          end
        end
      end
    end
  end

  task automatic send_bits(input logic [31:0] val, input int lo, input int hi,
                           input bit is_addr, input bit wr, input string name);
    for (int i = lo; i < hi; i++) begin
      int g = 0;
      bit acc;
      forever begin
        bus.ss = rand_mode ? ($urandom_range(0, 5) != 0) : 1'b1;
        bus.m_valid = rand_mode ? ($urandom_range(0, 5) != 0) : 1'b1;
        bus.m_ready = 1'($urandom);
        if (is_addr) begin
          bus.in_addr = val[i];
          bus.in_write = (i == 0) ? wr : 1'($urandom);
          bus.ser_wdata = 1'($urandom);
        end else begin
          bus.ser_wdata = val[i];
          bus.in_addr = 1'($urandom);
          bus.in_write = 1'($urandom);
        end
        @(negedge clk);
        acc = bus.ss && bus.m_valid && bus.s_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        g++;
        if (g > 200) begin
          timeout(name);
          bus.m_valid = 1'b0;
          return;
        end
      end
    end
    bus.m_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    bus.m_valid = 1'b0;
    while (!(exp_bits.size() == 0 && exp_req.size() == 0 && !bus.busy)) begin
      bus.ss = rand_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
      bus.m_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk);
      #1;
      g++;
      if (g > 400) begin
        timeout(name);
        return;
      end
    end
    bus.m_ready = 1'b0;
    check({name, "_sready"}, 32'(bus.s_ready), 32'd1);
    check({name, "_treq"}, 32'(bus.t_req), 32'd0);
  endtask

  task automatic wait_rvalid(input string name);
    int g = 0;
    bus.ss = 1'b1;
    bus.m_ready = 1'b0;
    while (!bus.ser_rvalid) begin
      @(posedge clk);
      #1;
      g++;
      if (g > 50) begin
        timeout(name);
        return;
      end
    end
  endtask

  task automatic give_bits(input int n, input string name);
    int got = 0;
    int g = 0;
    bit v;
    bus.ss = 1'b1;
    bus.m_ready = 1'b1;
    while (got < n) begin
      @(negedge clk);
      v = bus.ser_rvalid;
      @(posedge clk);
      #1;
      if (v) got++;
      g++;
      if (g > 100) begin
        timeout(name);
        break;
      end
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic expect_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_req.push_back('{1'b0, a, DW'(0)});
    rd_q.push_back(d);
    for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_req.push_back('{1'b1, a, d});
    send_bits(32'(a), 0, AW, 1'b1, 1'b1, "waddr");
    send_bits(32'(d), 0, DW, 1'b0, 1'b1, "wdata");
    wait_idle("write");
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay);
    ack_delay = delay;
    expect_read(a, d);
    send_bits(32'(a), 0, AW, 1'b1, 1'b0, "raddr");
    wait_idle("read");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rst_n = 1'b0;
    bus.ss = 1'b0;
    bus.m_valid = 1'b0;
    bus.in_write = 1'b0;
    bus.in_addr = 1'b0;
    bus.ser_wdata = 1'b0;
    bus.burst_en = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sready", 32'(bus.s_ready), 32'd1);
    check("rst_rvalid", 32'(bus.ser_rvalid), 32'd0);
    check("rst_rdata", 32'(bus.ser_rdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_treq", 32'(bus.t_req), 32'd0);
    check("rst_twrite", 32'(bus.t_write), 32'd0);
    check("rst_taddr", 32'(bus.t_addr), 32'd0);
    check("rst_twdata", 32'(bus.t_wdata), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write 0xA5 to 0x3C4 with zero-wait target; request must be up right after the final bit.
    ack_delay = 0;
    exp_req.push_back('{1'b1, 12'h3C4, 8'hA5});
    send_bits(32'h3C4, 0, AW, 1'b1, 1'b1, "a5_addr");
    send_bits(32'hA5, 0, DW, 1'b0, 1'b1, "a5_data");
    check("a5_treq_latency", 32'(bus.t_req), 32'd1);
    wait_idle("a5");
    check("a5_busy", 32'(bus.busy), 32'd0);

    do_read(12'h0FF, 8'h5A, 3);

    // ss dropped for 5 cycles after 4 address bits.
    exp_req.push_back('{1'b1, 12'h3C4, 8'h3C});
    send_bits(32'h3C4, 0, 4, 1'b1, 1'b1, "ss_lo");
    bus.ss = 1'b0;
    bus.m_valid = 1'b1;
    repeat (5) begin
      bus.in_addr = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("ss_hold_busy", 32'(bus.busy), 32'd1);
    check("ss_hold_sready", 32'(bus.s_ready), 32'd1);
    send_bits(32'h3C4, 4, AW, 1'b1, 1'b1, "ss_hi");
    send_bits(32'h3C, 0, DW, 1'b0, 1'b1, "ss_data");
    wait_idle("ss");

    // m_ready held low 4 cycles after two read bits.
    ack_delay = 1;
    expect_read(12'h155, 8'hC3);
    send_bits(32'h155, 0, AW, 1'b1, 1'b0, "stall_addr");
    wait_rvalid("stall_rvalid_wait");
    give_bits(2, "stall_first");
    repeat (4) begin
      @(negedge clk);
      check("stall_rdata", 32'(bus.ser_rdata), 32'(1'b0 ^ 8'hC3 >> 2 & 8'h1));
      check("stall_rvalid", 32'(bus.ser_rvalid), 32'd1);
      @(posedge clk);
      #1;
    end
    wait_idle("stall");

    // Burst write from 0xFFF.
    ack_delay = 0;
`ifdef BURST_SLAVE_PORT_BURST_EN
    exp_req.push_back('{1'b1, 12'hFFF, 8'h11});
    exp_req.push_back('{1'b1, 12'h000, 8'h22});
    exp_req.push_back('{1'b1, 12'h001, 8'h33});
    bus.burst_en = 1'b1;
    send_bits(32'hFFF, 0, AW, 1'b1, 1'b1, "burst_addr");
    send_bits(32'h11, 0, DW, 1'b0, 1'b1, "burst_d0");
    send_bits(32'h22, 0, DW, 1'b0, 1'b1, "burst_d1");
    send_bits(32'h33, 0, DW, 1'b0, 1'b1, "burst_d2");
    bus.burst_en = 1'b0;
    wait_idle("burst");
`else
    exp_req.push_back('{1'b1, 12'hFFF, 8'h11});
    bus.burst_en = 1'b1;
    send_bits(32'hFFF, 0, AW, 1'b1, 1'b1, "burst_addr");
    send_bits(32'h11, 0, DW, 1'b0, 1'b1, "burst_d0");
    wait_idle("burst");
    check("burst_off_busy", 32'(bus.busy), 32'd0);
    bus.burst_en = 1'b0;
`endif

    // Reset during RDATA bit 3.
    ack_delay = 0;
    expect_read(12'h2A7, 8'h96);
    send_bits(32'h2A7, 0, AW, 1'b1, 1'b0, "rstrd_addr");
    wait_rvalid("rstrd_rvalid_wait");
    give_bits(3, "rstrd_bits");
    rst_n = 1'b0;
    #1;
    check("rstrd_rvalid", 32'(bus.ser_rvalid), 32'd0);
    check("rstrd_treq", 32'(bus.t_req), 32'd0);
    check("rstrd_rdata", 32'(bus.ser_rdata), 32'd0);
    check("rstrd_busy", 32'(bus.busy), 32'd0);
    exp_bits.delete();
    exp_req.delete();
    rd_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(12'h010, 8'h3D, 0);

    // Reset while a read request is outstanding.
    ack_delay = 30;
    exp_req.push_back('{1'b0, 12'h4B1, DW'(0)});
    send_bits(32'h4B1, 0, AW, 1'b1, 1'b0, "rstreq_addr");
    check("rstreq_treq_up", 32'(bus.t_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstreq_treq_drop", 32'(bus.t_req), 32'd0);
    check("rstreq_taddr", 32'(bus.t_addr), 32'd0);
    exp_req.delete();
    rd_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with serial stalls and stray target acks.
    rand_mode = 1;
    repeat (40) begin
      a = AW'($urandom);
      d = DW'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read(a, d, $urandom_range(0, 3));
    end
    rand_mode = 0;

    check("final_req_queue", 32'(exp_req.size()), 32'd0);
    check("final_bit_queue", 32'(exp_bits.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
